piso_framer: RTL

- Parallel-in/serial-out framer that feeds the 4-bit serial-in shift register stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB first, one bit per clock, on a serial data line.
- Inserts a configurable idle gap between frames and flags the last bit, so the downstream register holds the complete word on the edge after that flag.

---
 rtl/piso_pkg.sv | 20 ++
 rtl/piso_framer_if.sv | 34 +++
 rtl/piso_gap_timer.sv | 26 ++
 rtl/piso_framer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// piso_framer shared package: FSM state encoding, default
// parameters and counter sizing helper.
package piso_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_GAP_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      GAP    = 2'd2,
      PARITY = 2'd3
   } state_t;

   // Bit counter width; never below one bit.
   function automatic int cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_framer_if.sv
// piso_framer bus: upstream word handshake plus the serial
// stream towards the shift register stage.
interface piso_framer_if
   import piso_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             ser_data;
   logic             ser_valid;
   logic             frame_done;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  ser_data,
      input  ser_valid,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output ser_data,
      output ser_valid,
      output frame_done
   );

endinterface

// File: rtl/piso_gap_timer.sv
// Loadable 4-bit down-counter; o_done is high once the count
// has reached zero. It saturates at zero instead of wrapping.
module piso_gap_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_load,
   input  logic [3:0] i_value,
   output logic       o_done
);

   logic [3:0] r_cnt;

   // Load on request, otherwise count down and hold at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != 4'd0) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end

   assign o_done = (r_cnt == 4'd0);

endmodule

// File: rtl/piso_framer.sv
// Parallel-in/serial-out framer, MSB first, with idle gap.
// Optional even-parity bit: define PIS_FRAMER_PARITY_EN.
module piso_framer
   import piso_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
   input logic         clk,
   input logic         rst,
   piso_framer_if.slave bus
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
   localparam logic HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [3:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t           r_state;
   logic [WIDTH-1:0] r_word;
   logic [CW-1:0]    r_cnt;
   logic             r_ser_data;
   logic             r_ser_valid;
   logic             r_frame_done;

   logic             w_accept;
   logic [CW-1:0]    w_cnt_nx;
   logic             w_gap_load;
   logic             w_gap_done;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_cnt_nx = r_cnt - CW'(1);

`ifdef PIS_FRAMER_PARITY_EN
   assign w_gap_load = HAS_GAP && (r_state == PARITY);
`else
   assign w_gap_load = HAS_GAP && (r_state == SHIFT)
                       && (r_cnt == '0);
`endif

   piso_gap_timer u_gap (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_gap_load),
      .i_value (GAP_LOAD),
      .o_done  (w_gap_done)
   );

   // Framer FSM; every output is registered so the bit shown in
   // a cycle is the one chosen at the preceding edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_word       <= '0;
         r_cnt        <= '0;
         r_ser_data   <= 1'b0;
         r_ser_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_word      <= bus.in_data;
                  r_cnt       <= LAST_IDX;
                  r_ser_data  <= bus.in_data[WIDTH-1];
                  r_ser_valid <= 1'b1;
                  r_state     <= SHIFT;
               end else begin
                  r_ser_data  <= 1'b0;
                  r_ser_valid <= 1'b0;
               end
            end
            SHIFT: begin
               if (r_cnt != '0) begin
                  r_cnt      <= w_cnt_nx;
                  r_ser_data <= r_word[w_cnt_nx];
`ifdef PIS_FRAMER_PARITY_EN
                  r_frame_done <= 1'b0;
`else
                  r_frame_done <= (w_cnt_nx == '0);
`endif
               end else begin
`ifdef PIS_FRAMER_PARITY_EN
                  r_ser_data   <= ^r_word;
                  r_frame_done <= 1'b1;
                  r_state      <= PARITY;
`else
                  r_ser_data  <= 1'b0;
                  r_ser_valid <= 1'b0;
                  r_state     <= HAS_GAP ? GAP : IDLE;
`endif
               end
            end
`ifdef PIS_FRAMER_PARITY_EN
            PARITY: begin
               r_ser_data  <= 1'b0;
               r_ser_valid <= 1'b0;
               r_state     <= HAS_GAP ? GAP : IDLE;
            end
`endif
            GAP: begin
               r_ser_data  <= 1'b0;
               r_ser_valid <= 1'b0;
               if (w_gap_done) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ser_data  <= 1'b0;
               r_ser_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready   = (r_state == IDLE);
   assign bus.ser_data   = r_ser_data;
   assign bus.ser_valid  = r_ser_valid;
   assign bus.frame_done = r_frame_done;

endmodule
